// File: rtl/wb_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_initiator                                                  |
// | Purpose  : Wishbone classic-cycle bus master fed by a valid/ready        |
// |            command stream; one response beat per bus cycle, timeout-safe |
// | Options  : define WB_INIT_BURST_EN for cmd_len_i and incrementing bursts |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_STEP      = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
`ifdef WB_INIT_BURST_EN
    input  logic [3:0]  cmd_len_i,
`endif
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    // The counter value sampled on the final permitted strobe cycle.
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_addr_step    = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [15:0] r_cnt;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic        r_rsp_last;

    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;
    logic        w_rsp_done;
    logic        w_more;

`ifdef WB_INIT_BURST_EN
    logic [3:0]  r_beats_left;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_beats_left <= 4'd0;
        end else if (w_accept) begin
            r_beats_left <= cmd_len_i;
        end else if (w_rsp_done && !r_rsp_last) begin
            r_beats_left <= r_beats_left - 4'd1;
        end
    end

    assign w_more = (r_beats_left != 4'd0);
`else
    assign w_more = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                // An ack on the timeout edge still completes the beat cleanly.
                if (r_cyc && r_stb && wbm_ack_i) begin
                    w_ack        = 1'b1;
                    w_state_next = ST_RSP;
                end else if (r_cnt == c_timeout_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = r_rsp_last ? ST_IDLE : ST_BUS;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_cnt       <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
                r_sel <= cmd_sel_i;
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_cnt <= 16'd0;
            end
            if ((r_state == ST_BUS) && !w_ack && !w_timeout) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_ack || w_timeout) begin
                r_cyc       <= 1'b0;
                r_stb       <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_timeout;
                r_rsp_dat   <= (w_ack && !r_we) ? wbm_dat_i : 32'd0;
                r_rsp_last  <= w_timeout || !w_more;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                // Next burst beat: bump the address, reuse data and selects.
                if (!r_rsp_last) begin
                    r_adr <= r_adr + c_addr_step;
                    r_cyc <= 1'b1;
                    r_stb <= 1'b1;
                    r_cnt <= 16'd0;
                end
            end
        end
    end

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_last_o  = r_rsp_last;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;

endmodule
`default_nettype wire
